array_shift_var_delay: RTL

//   Multi-channel, runtime-programmable delay line with shift enable and per-stage valid tracking.
//   All NCH lanes move in lockstep. A lane is a signed DW-bit word.

---
 rtl/array_delay_pkg.sv | 23 ++
 rtl/array_shift_var_delay.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/array_delay_pkg.sv
// ---------------------------------------------------------------------------
// array_delay_pkg
//   Shared types and helpers for the runtime-programmable delay line.
//   - state_t     : fill/run status of the line
//   - clamp_depth : forces a requested depth into the legal range 1..max
// ---------------------------------------------------------------------------
package array_delay_pkg;

    typedef enum logic {S_FILL, S_RUN} state_t;

    // A depth of zero has no tap to read, so it becomes 1.
    // Anything beyond the physical line length becomes the full length.
    function automatic int clamp_depth(input int d, input int max);
        if (d < 1) begin
            return 1;
        end else if (d > max) begin
            return max;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/array_shift_var_delay.sv
// ---------------------------------------------------------------------------
// array_shift_var_delay
//   Multi-channel delay line with run-time depth, shift enable, per-stage
//   valid tracking, flush and a primed status. All NCH lanes share one packed
//   NCH*DW word per stage, so a single array shift moves every channel.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous reset, active-low
//   cfg_depth  in   requested depth, applied on cfg_load (clamped 1..MAX_LEN)
//   cfg_load   in   apply cfg_depth; also flushes the valid bits
//   flush      in   clear all stage valid bits and restart the fill count
//   shift_en   in   advance the line by one stage
//   d_in       in   lane k = d_in[k*DW +: DW]
//   d_in_val   in   qualifier for d_in, sampled only when shift_en=1
//   d_out      out  data at tap depth_q-1
//   d_out_val  out  valid bit at tap depth_q-1
//   primed     out  tap holds a sample accepted since the last flush/load
//   depth_q    out  active depth
// ---------------------------------------------------------------------------
module array_shift_var_delay
    import array_delay_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int DEF_LEN = 8,
    parameter int DW      = 16,
    parameter int NCH     = 4,
    parameter int OUT_REG = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_depth,
    input  logic                         cfg_load,
    input  logic                         flush,
    input  logic                         shift_en,
    input  logic [NCH*DW-1:0]            d_in,
    input  logic                         d_in_val,
    output logic [NCH*DW-1:0]            d_out,
    output logic                         d_out_val,
    output logic                         primed,
    output logic [$clog2(MAX_LEN+1)-1:0] depth_q
);

    localparam int DEPW = $clog2(MAX_LEN + 1);
    localparam int IDXW = $clog2(MAX_LEN);
    localparam int LW   = NCH * DW;

    logic [LW-1:0]      stage_data [MAX_LEN];
    logic [MAX_LEN-1:0] stage_val;
    state_t             state;
    logic [DEPW-1:0]    fill_cnt;

    logic               clr;
    logic [DEPW-1:0]    last_cnt;
    logic [IDXW-1:0]    tap_idx;
    logic [LW-1:0]      tap_data;
    logic               tap_val;
    logic               run_now;

    assign clr      = flush | cfg_load;
    assign last_cnt = depth_q - DEPW'(1);
    // depth_q is always 1..MAX_LEN, so depth_q-1 fits the stage index.
    assign tap_idx  = IDXW'(last_cnt);
    assign tap_data = stage_data[tap_idx];
    assign tap_val  = stage_val[tap_idx];
    assign run_now  = (state == S_RUN);

    // ---- stage 0..MAX_LEN-1: shift register, data and valid ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                stage_data[i] <= '0;
            end
            stage_val <= '0;
        end else begin
            if (shift_en) begin
                stage_data[0] <= d_in;
                for (int i = 1; i < MAX_LEN; i++) begin
                    stage_data[i] <= stage_data[i-1];
                end
                stage_val <= {stage_val[MAX_LEN-2:0], d_in_val};
            end
            // Overrides the shift above, including the word entering s[0],
            // so nothing accepted around a flush can surface as valid.
            if (clr) begin
                stage_val <= '0;
            end
        end
    end

    // ---- depth register and fill/run FSM ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            depth_q  <= DEPW'(DEF_LEN);
            state    <= S_FILL;
            fill_cnt <= '0;
        end else begin
            if (cfg_load) begin
                depth_q <= DEPW'(clamp_depth(int'(cfg_depth), MAX_LEN));
            end
            if (clr) begin
                state    <= S_FILL;
                fill_cnt <= '0;
            end else begin
                case (state)
                    S_FILL: begin
                        if (shift_en) begin
                            if (fill_cnt == last_cnt) begin
                                state <= S_RUN;
                            end else begin
                                fill_cnt <= fill_cnt + DEPW'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        fill_cnt <= last_cnt;
                    end
                    default: begin
                        state    <= S_FILL;
                        fill_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // ---- output stage: combinational tap or one register ----
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [LW-1:0] out_data_p1;
            logic          out_val_p1;
            logic          primed_p1;

            // Free-running: tracks the tap every cycle, not just on shifts.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    out_data_p1 <= '0;
                    out_val_p1  <= 1'b0;
                    primed_p1   <= 1'b0;
                end else begin
                    out_data_p1 <= tap_data;
                    out_val_p1  <= tap_val;
                    primed_p1   <= run_now;
                end
            end

            assign d_out     = out_data_p1;
            assign d_out_val = out_val_p1;
            assign primed    = primed_p1;
        end else begin : g_out_comb
            assign d_out     = tap_data;
            assign d_out_val = tap_val;
            assign primed    = run_now;
        end
    endgenerate

endmodule
